lap_countdown_timer: RTL and testbench
======================================

# lap_countdown_timer

Parametrised successor to the single-channel 100 Hz timer: one block provides a countdown timer with a latched alarm and a stopwatch with an indexed lap memory, driven by an internal tick prescaler from the system clock. It sits between the debounced front-panel buttons (`modeInput`, `startOrStop`, `splitOrReset`) and the display/alarm logic. It replaces the free-running millisecond counter with explicit, resettable state machines.

## Interface
- `CLK_PER_TICK`, default 1000: system clocks per count tick (≥2).
- `CNT_W`, default 32: width of count, preset and lap values.
- `LAP_DEPTH`, default 8: lap entries stored; power of two. `LAP_AW = $clog2(LAP_DEPTH)` is a localparam.

Ports:
- `clockSignal`  in  1  system clock, all logic on rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `modeInput`  in  1  button level, already synchronised and debounced; rising edge toggles mode.
- `startOrStop`  in  1  button level; rising edge = start/pause/resume/acknowledge.
- `splitOrReset`  in  1  button level; rising edge = lap/clear/acknowledge.
- `loadValue`  in  CNT_W  countdown preset in ticks, sampled on start from IDLE.
- `lapReadIndex`  in  LAP_AW  lap entry to read.
- `tickCount`  out  CNT_W  current count.
- `mode`  out  1  0 = countdown, 1 = stopwatch.
- `running`  out  1  high in RUN.
- `lapData`  out  CNT_W  registered lap read data.
- `lapCount`  out  LAP_AW+1  laps stored, 0..LAP_DEPTH.
- `lapOverflow`  out  1  sticky: lap requested with memory full.
- `ringSound`  out  1  countdown expired; held until acknowledged.

## Operation
- Press detection: each button registered once; press = current & ~previous. One press per rising edge, regardless of hold length.
- Prescaler: counts 0..CLK_PER_TICK-1 only in RUN. Tick pulse on the cycle it equals CLK_PER_TICK-1, then wraps to 0. Holds its value in PAUSE. Cleared on entering IDLE or on a start from IDLE.
- States: IDLE, RUN, PAUSE, RING. RING exists in countdown only.
- Press priority in one cycle: startOrStop > splitOrReset > modeInput. Lower-priority presses in the same cycle are discarded.
- Countdown (mode=0):
  - IDLE + start: if loadValue≠0, tickCount←loadValue and go to RUN. If loadValue==0, ignore.
  - RUN + tick: tickCount−1. The tick that makes it 0 goes to RING with ringSound←1.
  - RUN + start: go to PAUSE. RUN + split: ignored.
  - PAUSE + start: go to RUN. PAUSE + split: go to IDLE with tickCount←0.
  - RING + start or split: ringSound←0, go to IDLE, tickCount stays 0.
- Stopwatch (mode=1):
  - IDLE + start: go to RUN from tickCount=0.
  - RUN + tick: tickCount+1, saturating at 2^CNT_W−1 (no wrap).
  - RUN + split: if lapCount<LAP_DEPTH, write the current tickCount register value to entry lapCount and increment lapCount. Otherwise lapOverflow←1 with no write.
  - RUN + start: go to PAUSE. PAUSE + start: go to RUN.
  - PAUSE + split: go to IDLE, clearing tickCount, lapCount and lapOverflow.
- Mode press is honoured only in IDLE. It toggles mode and clears tickCount, lapCount, lapOverflow and ringSound. In other states it is ignored.
- A press and a tick in the same cycle: the press wins and the tick is discarded. Exception: stopwatch RUN + split + tick captures the pre-increment value and also increments.
- Lap read: lapData ← (lapReadIndex < lapCount) ? mem[lapReadIndex] : 0, registered.

## Timing
- Reset (resetN low, asynchronous): state IDLE, mode 0, tickCount 0, running 0, lapData 0, lapCount 0, lapOverflow 0, ringSound 0, prescaler 0. Lap memory contents are not reset; the lapCount gating above hides them.
- Button edge at cycle N (input sampled high, previous low): state/count change is visible after edge N+1.
- First tick after a start: CLK_PER_TICK cycles after the state change to RUN.
- Expiry: ringSound and state RING assert on the same edge the count reaches 0. running drops on that edge.
- lapData latency: 1 cycle from lapReadIndex or lapCount change.
- A reset during RUN or RING takes effect immediately; no pending press survives it.

## Test plan
- Countdown, CLK_PER_TICK=4, loadValue=3, start → tickCount 3,2,1,0 at 4-cycle spacing; ringSound=1, running=0 on the 0 edge; a split press clears ringSound and goes to IDLE.
- Countdown pause: start, then pause after 1 tick (count 2); hold 20 cycles → count stays 2; resume → next tick exactly 4 − elapsed prescaler cycles later.
- Stopwatch, LAP_DEPTH=4: 5 splits at counts 2,4,6,8,10 → lapCount=4, entries 2,4,6,8, lapOverflow=1; lapReadIndex=3 → lapData=8 one cycle later.
- Simultaneous start + split + mode in countdown IDLE, loadValue=5 → only the start acts: RUN with count 5, mode unchanged.
- Stopwatch saturation, CNT_W=4: run 20 ticks → tickCount holds at 15.
- Assert resetN mid-RUN with ringSound=0 and mid-RING → all outputs at their reset values asynchronously; a mode press in RUN is ignored.

Source files
------------

// File: rtl/lap_countdown_timer.sv
// Countdown timer with latched alarm plus stopwatch with indexed lap memory,
// both stepped by an internal tick prescaler running off the system clock.
module lap_countdown_timer #(
  parameter int unsigned CLK_PER_TICK = 1000,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned LAP_DEPTH    = 8,
  localparam int unsigned LAP_AW      = $clog2(LAP_DEPTH)
) (
  input  logic              clockSignal,
  input  logic              resetN,
  input  logic              modeInput,
  input  logic              startOrStop,
  input  logic              splitOrReset,
  input  logic [CNT_W-1:0]  loadValue,
  input  logic [LAP_AW-1:0] lapReadIndex,
  output logic [CNT_W-1:0]  tickCount,
  output logic              mode,
  output logic              running,
  output logic [CNT_W-1:0]  lapData,
  output logic [LAP_AW:0]   lapCount,
  output logic              lapOverflow,
  output logic              ringSound
);

  localparam int unsigned      PS_W     = $clog2(CLK_PER_TICK);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_PER_TICK - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [LAP_AW:0]  LAP_FULL = (LAP_AW+1)'(LAP_DEPTH);

  // state    | meaning
  // ST_IDLE  | stopped, count cleared or expired; mode changes allowed
  // ST_RUN   | prescaler advancing, count stepping on each tick
  // ST_PAUSE | count and prescaler frozen
  // ST_RING  | countdown reached 0, alarm latched until acknowledged
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_RING} state_t;

  state_t state, state_nx;

  logic [2:0]       btn_q, btn_prev, press;
  logic             do_start, do_split, do_mode;
  logic [PS_W-1:0]  presc;
  logic             tick;
  logic [CNT_W-1:0] cnt_q, lap_rd;
  logic             mode_q, ring_q, ovf_q;
  logic [LAP_AW:0]  lap_cnt;
  logic             cnt_last, lap_full;
  logic             cnt_load, cnt_clear, cnt_dec, cnt_inc;
  logic             lap_req, lap_clear, ring_set, ring_clr, mode_flip;
  logic [CNT_W-1:0] lap_mem [LAP_DEPTH];

  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      btn_q    <= '0;
      btn_prev <= '0;
    end else begin
      btn_q    <= {modeInput, splitOrReset, startOrStop};
      btn_prev <= btn_q;
    end
  end

  assign press    = btn_q & ~btn_prev;
  assign do_start = press[0];
  assign do_split = press[1] & ~press[0];
  assign do_mode  = press[2] & ~(|press[1:0]);

  assign tick     = (state == ST_RUN) && (presc == PS_LAST);
  assign cnt_last = (cnt_q <= CNT_W'(1));
  assign lap_full = (lap_cnt == LAP_FULL);

  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (do_start && (mode_q || (|loadValue))) state_nx = ST_RUN;
      ST_RUN: begin
        if (do_start)                          state_nx = ST_PAUSE;
        else if (!mode_q && tick && cnt_last)  state_nx = ST_RING;
      end
      ST_PAUSE: begin
        if (do_start)      state_nx = ST_RUN;
        else if (do_split) state_nx = ST_IDLE;
      end
      ST_RING:  if (do_start || do_split) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    cnt_dec   = 1'b0;
    cnt_inc   = 1'b0;
    lap_req   = 1'b0;
    lap_clear = 1'b0;
    ring_set  = 1'b0;
    ring_clr  = 1'b0;
    mode_flip = 1'b0;
    running   = (state == ST_RUN);
    unique case (state)
      ST_IDLE: begin
        if (do_start) begin
          cnt_load  = !mode_q && (|loadValue);
          cnt_clear = mode_q;
        end else if (do_mode) begin
          mode_flip = 1'b1;
          cnt_clear = 1'b1;
          lap_clear = 1'b1;
          ring_clr  = 1'b1;
        end
      end
      // a start press swallows a coincident tick; a split lap keeps it
      ST_RUN: begin
        if (!do_start) begin
          cnt_dec  = !mode_q && tick;
          cnt_inc  = mode_q && tick;
          lap_req  = mode_q && do_split;
          ring_set = !mode_q && tick && cnt_last;
        end
      end
      ST_PAUSE: begin
        if (!do_start && do_split) begin
          cnt_clear = 1'b1;
          lap_clear = mode_q;
        end
      end
      ST_RING: ring_clr = do_start | do_split;
      default: ;
    endcase
  end

  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      ring_q  <= 1'b0;
      ovf_q   <= 1'b0;
      lap_cnt <= '0;
      presc   <= '0;
      lap_rd  <= '0;
    end else begin
      if (cnt_load)                          cnt_q <= loadValue;
      else if (cnt_clear)                    cnt_q <= '0;
      else if (cnt_dec && cnt_q != '0)       cnt_q <= cnt_q - CNT_W'(1);
      else if (cnt_inc && cnt_q != CNT_MAX)  cnt_q <= cnt_q + CNT_W'(1);

      if (mode_flip) mode_q <= ~mode_q;

      if (ring_set)      ring_q <= 1'b1;
      else if (ring_clr) ring_q <= 1'b0;

      if (lap_clear) begin
        lap_cnt <= '0;
        ovf_q   <= 1'b0;
      end else if (lap_req) begin
        if (lap_full) ovf_q   <= 1'b1;
        else          lap_cnt <= lap_cnt + (LAP_AW+1)'(1);
      end

      if (state_nx == ST_IDLE || state == ST_IDLE) presc <= '0;
      else if (state == ST_RUN) presc <= (presc == PS_LAST) ? '0 : presc + PS_W'(1);

      lap_rd <= ({1'b0, lapReadIndex} < lap_cnt) ? lap_mem[lapReadIndex] : '0;
    end
  end

  // lap storage is not reset; lap_cnt gating hides stale entries
  always_ff @(posedge clockSignal) begin
    if (lap_req && !lap_full) lap_mem[lap_cnt[LAP_AW-1:0]] <= cnt_q;
  end

  assign tickCount   = cnt_q;
  assign mode        = mode_q;
  assign lapData     = lap_rd;
  assign lapCount    = lap_cnt;
  assign lapOverflow = ovf_q;
  assign ringSound   = ring_q;

endmodule

// File: tb/tb_lap_countdown_timer.sv
// Bench for lap_countdown_timer: vector table, directed corner sequences and
// a randomized run against a behavioural model (CLK_PER_TICK=4, CNT_W=4, LAP_DEPTH=4).
module tb_lap_countdown_timer;

  localparam int CPT = 4, DEPTH = 4, CMAX = 15;

  logic       clockSignal, resetN;
  logic       modeInput, startOrStop, splitOrReset;
  logic [3:0] loadValue;
  logic [1:0] lapReadIndex;
  logic [3:0] tickCount, lapData;
  logic       mode, running, lapOverflow, ringSound;
  logic [2:0] lapCount;

  lap_countdown_timer #(.CLK_PER_TICK(CPT), .CNT_W(4), .LAP_DEPTH(DEPTH)) dut (
    .clockSignal (clockSignal),
    .resetN      (resetN),
    .modeInput   (modeInput),
    .startOrStop (startOrStop),
    .splitOrReset(splitOrReset),
    .loadValue   (loadValue),
    .lapReadIndex(lapReadIndex),
    .tickCount   (tickCount),
    .mode        (mode),
    .running     (running),
    .lapData     (lapData),
    .lapCount    (lapCount),
    .lapOverflow (lapOverflow),
    .ringSound   (ringSound)
  );

  initial clockSignal = 1'b0;
  always #5 clockSignal = ~clockSignal;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] btn;   // {mode, split, start} levels for one cycle
    logic [3:0] load;
    int         cycles;
    logic [3:0] exp_count;
    logic       exp_mode;
    logic       exp_running;
    logic       exp_ring;
  } vec_t;

  vec_t vecs[13];

  // behavioural reference: laps kept as a queue, ticks derived from RUN cycles
  int  m_state;  // 0 idle, 1 run, 2 pause, 3 ring
  int  m_count, m_lapdata, m_run_cyc;
  bit  m_mode, m_ring, m_ovf;
  int  laps[$];
  bit [2:0] h1, h2;

  function automatic void model_reset();
    m_state = 0; m_count = 0; m_lapdata = 0; m_run_cyc = 0;
    m_mode = 0; m_ring = 0; m_ovf = 0;
    laps.delete();
    h1 = 3'b000; h2 = 3'b000;
  endfunction

  function automatic void model_step(input bit [2:0] lvl, input int load, input int idx);
    bit [2:0] pr;
    bit tick;
    int ev;
    pr = h1 & ~h2;
    ev = pr[0] ? 1 : (pr[1] ? 2 : (pr[2] ? 3 : 0));
    m_lapdata = (idx < laps.size()) ? laps[idx] : 0;
    tick = (m_state == 1) && ((m_run_cyc % CPT) == CPT - 1);
    if (m_state == 1) m_run_cyc++;
    case (m_state)
      0: begin
        if (ev == 1) begin
          if (m_mode || load != 0) begin
            m_state = 1; m_count = m_mode ? 0 : load; m_run_cyc = 0;
          end
        end else if (ev == 3) begin
          m_mode = !m_mode; m_count = 0; laps.delete(); m_ovf = 0; m_ring = 0;
        end
      end
      1: begin
        if (ev == 1) m_state = 2;
        else if (m_mode) begin
          if (ev == 2) begin
            if (laps.size() < DEPTH) laps.push_back(m_count);
            else m_ovf = 1;
          end
          if (tick && m_count < CMAX) m_count++;
        end else if (tick) begin
          m_count--;
          if (m_count == 0) begin m_state = 3; m_ring = 1; end
        end
      end
      2: begin
        if (ev == 1) m_state = 1;
        else if (ev == 2) begin
          m_state = 0; m_count = 0; m_run_cyc = 0;
          if (m_mode) begin laps.delete(); m_ovf = 0; end
        end
      end
      default: begin
        if (ev == 1 || ev == 2) begin m_state = 0; m_ring = 0; m_run_cyc = 0; end
      end
    endcase
    h2 = h1;
    h1 = lvl;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clockSignal);
  endtask

  // returns just after the edge on which the press acts
  task automatic press(input int b);
    if (b == 0) startOrStop = 1'b1; else if (b == 1) splitOrReset = 1'b1; else modeInput = 1'b1;
    step();
    startOrStop = 1'b0; splitOrReset = 1'b0; modeInput = 1'b0;
    step();
  endtask

  task automatic wait_count(input int target, output int cyc);
    cyc = 0;
    while (int'(tickCount) != target && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_vec++;
    if ({tickCount, mode, running, lapData, lapCount, lapOverflow, ringSound} !== 15'd0) begin
      n_err++;
      $display("FAIL %s: got cnt=%0d mode=%b run=%b lapData=%0d lapCount=%0d ovf=%b ring=%b, expected all zero",
               name, tickCount, mode, running, lapData, lapCount, lapOverflow, ringSound);
    end
  endtask

  initial begin
    int cyc;
    bit [2:0] lvl;

    vecs[0]  = '{3'b001, 4'd3, 2, 4'd3, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{3'b000, 4'd3, 3, 4'd3, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'b000, 4'd3, 1, 4'd2, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'b000, 4'd3, 4, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{3'b000, 4'd3, 3, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'b000, 4'd3, 1, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{3'b010, 4'd3, 2, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b100, 4'd3, 2, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'b100, 4'd3, 2, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b111, 4'd5, 2, 4'd5, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{3'b001, 4'd5, 2, 4'd5, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b010, 4'd5, 2, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'b001, 4'd0, 2, 4'd0, 1'b0, 1'b0, 1'b0};

    resetN = 1'b0;
    modeInput = 1'b0; startOrStop = 1'b0; splitOrReset = 1'b0;
    loadValue = 4'd0; lapReadIndex = 2'd0;
    repeat (3) step();
    check_reset_outputs("reset state");
    resetN = 1'b1;

    foreach (vecs[i]) begin
      {modeInput, splitOrReset, startOrStop} = vecs[i].btn;
      loadValue = vecs[i].load;
      step();
      {modeInput, splitOrReset, startOrStop} = 3'b000;
      repeat (vecs[i].cycles - 1) step();
      n_vec++;
      if ({tickCount, mode, running, ringSound} !==
          {vecs[i].exp_count, vecs[i].exp_mode, vecs[i].exp_running, vecs[i].exp_ring}) begin
        n_err++;
        $display("FAIL vec[%0d]: got cnt=%0d mode=%b run=%b ring=%b, expected cnt=%0d mode=%b run=%b ring=%b",
                 i, tickCount, mode, running, ringSound,
                 vecs[i].exp_count, vecs[i].exp_mode, vecs[i].exp_running, vecs[i].exp_ring);
      end
    end

    // countdown pause and resume keeps the partial prescaler phase
    loadValue = 4'd3;
    press(0);
    wait_count(2, cyc);
    check("first tick spacing", cyc, 4);
    press(0);
    repeat (20) step();
    check("paused count", tickCount, 2);
    check("paused running", running, 0);
    press(0);
    wait_count(1, cyc);
    check("resume tick delay", cyc, 2);
    press(0);
    press(1);
    check("pause split clears", tickCount, 0);

    // stopwatch laps with overflow
    press(2);
    check("mode to stopwatch", mode, 1);
    press(0);
    for (int k = 1; k <= 5; k++) begin
      wait_count(2 * k, cyc);
      check($sformatf("lap %0d wait", k), cyc, (k == 1) ? 8 : 6);
      press(1);
    end
    check("lapCount full", lapCount, 4);
    check("lapOverflow", lapOverflow, 1);
    lapReadIndex = 2'd3;
    step();
    check("lapData[3]", lapData, 8);
    lapReadIndex = 2'd0;
    step();
    check("lapData[0]", lapData, 2);
    lapReadIndex = 2'd1;
    step();
    check("lapData[1]", lapData, 4);
    press(0);
    press(1);
    check("laps cleared", {lapCount, lapOverflow, tickCount}, 0);
    lapReadIndex = 2'd3;
    step();
    check("lapData gated", lapData, 0);

    // saturation, ignored mode press in RUN, then async reset mid-RUN
    press(0);
    press(2);
    check("mode press in RUN", {mode, running}, 3);
    repeat (90) step();
    check("saturated count", tickCount, 15);
    press(1);
    lapReadIndex = 2'd0;
    step();
    check("lap of saturated count", lapData, 15);
    #2 resetN = 1'b0;
    #1 check_reset_outputs("reset mid-RUN");
    step();
    resetN = 1'b1;

    // async reset while ringing
    loadValue = 4'd1;
    press(0);
    cyc = 0;
    while (!ringSound && cyc < 20) begin step(); cyc++; end
    check("ring reached", {ringSound, running, tickCount}, 32);
    #2 resetN = 1'b0;
    #1 check_reset_outputs("reset mid-RING");
    step();
    resetN = 1'b1;

    // randomized run against the model
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    model_reset();
    lvl = 3'b000;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) lvl[0] = ~lvl[0];
      if ($urandom_range(0, 7) == 0)  lvl[1] = ~lvl[1];
      if ($urandom_range(0, 9) == 0)  lvl[2] = ~lvl[2];
      {modeInput, splitOrReset, startOrStop} = lvl;
      loadValue    = 4'($urandom_range(0, 5));
      lapReadIndex = 2'($urandom_range(0, 3));
      @(posedge clockSignal);
      model_step(lvl, int'(loadValue), int'(lapReadIndex));
      @(negedge clockSignal);
      n_vec++;
      if (tickCount !== 4'(m_count) || mode !== m_mode || running !== (m_state == 1) ||
          lapData !== 4'(m_lapdata) || lapCount !== 3'(laps.size()) ||
          lapOverflow !== m_ovf || ringSound !== m_ring) begin
        n_err++;
        $display("FAIL rand[%0d]: got cnt=%0d mode=%b run=%b lapData=%0d lapCount=%0d ovf=%b ring=%b, expected cnt=%0d mode=%b run=%b lapData=%0d lapCount=%0d ovf=%b ring=%b",
                 c, tickCount, mode, running, lapData, lapCount, lapOverflow, ringSound,
                 m_count, m_mode, (m_state == 1), m_lapdata, laps.size(), m_ovf, m_ring);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
